// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage load/store engine.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int TIMEOUT_W = 8;

    // The unused size encoding 2'b11 behaves as a full word.
    function automatic mem_size_t norm_size(input logic [1:0] s);
        case (s)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input mem_size_t s, input logic [1:0] off);
        case (s)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return ~off[0];
            default:  return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load lane select with extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o     = 4'b1111;
        wdata_o  = wdata_i;
        rdata_o  = rdata_i;
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        case (size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                case (off_i)
                    2'd0:    byte_sel = rdata_i[7:0];
                    2'd1:    byte_sel = rdata_i[15:8];
                    2'd2:    byte_sel = rdata_i[23:16];
                    default: byte_sel = rdata_i[31:24];
                endcase
                rdata_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            MEM_HALF: begin
                be_o     = 4'b0011 << off_i;
                wdata_o  = {2{wdata_i[15:0]}};
                half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
                rdata_o  = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: issues one req/ack bus access per op and stalls
// the pipeline until the response (or timeout) is available for writeback.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_m_i,
    input  logic        mem_write_m_i,
    input  logic [1:0]  mem_size_m_i,
    input  logic        mem_unsigned_m_i,
    input  logic [31:0] addr_m_i,
    input  logic [31:0] write_data_m_i,
    output logic [31:0] read_data_m_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam bit                   TO_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    mem_state_t           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [3:0]           bus_be_q, bus_be_d;
    logic [31:0]          bus_wdata_q, bus_wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 bus_err_q, bus_err_d;
    mem_size_t            size_q, size_d;
    logic [1:0]           off_q, off_d;
    logic                 uns_q, uns_d;
    logic                 load_q, load_d;

    mem_size_t   size_in, al_size;
    logic [1:0]  al_off;
    logic        al_uns, op_any, aligned, in_idle;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata;

    // One aligner serves both directions: live inputs in IDLE, captured copies afterwards.
    assign size_in = norm_size(mem_size_m_i);
    assign op_any  = mem_read_m_i | mem_write_m_i;
    assign aligned = is_aligned(size_in, addr_m_i[1:0]);
    assign in_idle = (state_q == IDLE);
    assign al_size = in_idle ? size_in : size_q;
    assign al_off  = in_idle ? addr_m_i[1:0] : off_q;
    assign al_uns  = in_idle ? mem_unsigned_m_i : uns_q;

    mem_lane_align u_align (
        .size_i     (al_size),
        .off_i      (al_off),
        .unsigned_i (al_uns),
        .wdata_i    (write_data_m_i),
        .rdata_i    (bus_rdata_i),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        load_d      = load_q;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_any && !aligned) begin
                    misalign_o = 1'b1;
                end else if (op_any) begin
                    stall_o     = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write_m_i;
                    bus_addr_d  = {addr_m_i[31:2], 2'b00};
                    bus_be_d    = lane_be;
                    bus_wdata_d = lane_wdata;
                    size_d      = size_in;
                    off_d       = addr_m_i[1:0];
                    uns_d       = mem_unsigned_m_i;
                    load_d      = ~mem_write_m_i;
                    cnt_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + TIMEOUT_W'(1);
                // An ack on the final allowed cycle still completes normally.
                if (bus_ack_i) begin
                    if (load_q) rdata_d = lane_rdata;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    rdata_d   = '0;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst_i) begin
            stall_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            size_q      <= MEM_BYTE;
            off_q       <= '0;
            uns_q       <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            load_q      <= load_d;
        end
    end

    assign read_data_m_o = rdata_q;
    assign bus_err_o     = bus_err_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_be_o      = bus_be_q;
    assign bus_wdata_o   = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected bus requests and
// completions from a byte-level reference model; a negedge monitor pops and compares.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_read_m_i, mem_write_m_i, mem_unsigned_m_i;
    logic [1:0]  mem_size_m_i;
    logic [31:0] addr_m_i, write_data_m_i;
    logic [31:0] read_data_m_o;
    logic        stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_read_m_i     (mem_read_m_i),
        .mem_write_m_i    (mem_write_m_i),
        .mem_size_m_i     (mem_size_m_i),
        .mem_unsigned_m_i (mem_unsigned_m_i),
        .addr_m_i         (addr_m_i),
        .write_data_m_i   (write_data_m_i),
        .read_data_m_o    (read_data_m_o),
        .stall_o          (stall_o),
        .misalign_o       (misalign_o),
        .bus_err_o        (bus_err_o),
        .bus_req_o        (bus_req_o),
        .bus_we_o         (bus_we_o),
        .bus_addr_o       (bus_addr_o),
        .bus_be_o         (bus_be_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_ack_i        (bus_ack_i),
        .bus_rdata_i      (bus_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } done_exp_t;

    req_exp_t    req_q[$];
    done_exp_t   done_q[$];
    logic [31:0] mis_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Reference model: plain byte arithmetic on the access rules.
    function automatic int m_nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % m_nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] o);
        logic [7:0] t;
        t = ((8'd1 << m_nbytes(sz)) - 8'd1) << o;
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        int nb;
        nb = m_nbytes(sz);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_extract(input logic [1:0] sz, input logic [1:0] o,
                                              input logic uns, input logic [31:0] rd);
        int nb, sh;
        logic [31:0] v, mask;
        nb = m_nbytes(sz);
        if (nb == 1) sh = 8 * int'(o);
        else if (nb == 2) sh = o[1] ? 16 : 0;
        else sh = 0;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rd >> sh) & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic scramble_inputs();
        mem_read_m_i     = 1'($urandom_range(0, 1));
        mem_write_m_i    = 1'($urandom_range(0, 1));
        mem_size_m_i     = 2'($urandom_range(0, 3));
        mem_unsigned_m_i = 1'($urandom_range(0, 1));
        addr_m_i         = $urandom;
        write_data_m_i   = $urandom;
    endtask

    // wait_n: index of the WAIT cycle carrying ack; negative or >= TO means no ack.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int wait_n, input logic [31:0] rdata);
        req_exp_t  r;
        done_exp_t d;
        int        nwait;
        logic      tmo;
        @(posedge clk_i); #1;
        mem_read_m_i     = rd;
        mem_write_m_i    = wr;
        mem_size_m_i     = sz;
        mem_unsigned_m_i = uns;
        addr_m_i         = addr;
        write_data_m_i   = wd;
        bus_ack_i        = 1'b0;
        bus_rdata_i      = $urandom;
        if (!(rd | wr)) return;
        if (!m_aligned(sz, addr)) begin
            mis_q.push_back(model_rdata);
            return;
        end
        r.we    = wr;
        r.addr  = addr & 32'hFFFF_FFFC;
        r.be    = m_be(sz, addr[1:0]);
        r.wdata = m_wdata(sz, wd);
        req_q.push_back(r);
        tmo   = (wait_n < 0) || (wait_n >= TO);
        nwait = tmo ? TO : wait_n + 1;
        if (tmo) model_rdata = 32'h0;
        else if (!wr) model_rdata = m_extract(sz, addr[1:0], uns, rdata);
        d.rdata  = model_rdata;
        d.err    = tmo;
        d.stalls = 1 + nwait;
        done_q.push_back(d);
        for (int k = 0; k < nwait; k++) begin
            @(posedge clk_i); #1;
            scramble_inputs();
            bus_ack_i   = (k == wait_n);
            bus_rdata_i = (k == wait_n) ? rdata : $urandom;
        end
        // DONE cycle: a stray ack here must be ignored.
        @(posedge clk_i); #1;
        scramble_inputs();
        bus_ack_i   = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom;
    endtask

    task automatic idle_cycle();
        do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic reset_mid_wait(input logic [31:0] addr);
        req_exp_t r;
        @(posedge clk_i); #1;
        mem_read_m_i = 1'b1; mem_write_m_i = 1'b0; mem_size_m_i = 2'b10;
        mem_unsigned_m_i = 1'b0; addr_m_i = addr; bus_ack_i = 1'b0;
        r.we = 1'b0; r.addr = addr; r.be = 4'hF; r.wdata = 32'h0;
        req_q.push_back(r);
        @(posedge clk_i); #1;
        mem_read_m_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFE_F00D;
        model_rdata = 32'h0;
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0;
    endtask

    initial begin : monitor
        logic        prev_req, prev_rst;
        int          stall_cnt;
        req_exp_t    cur;
        done_exp_t   d;
        logic [31:0] m;
        prev_req  = 1'b0;
        prev_rst  = 1'b1;
        stall_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_req  = 1'b0;
                prev_rst  = 1'b1;
                stall_cnt = 0;
            end else begin
                if (prev_rst) begin
                    check("rst bus_req", 32'(bus_req_o), 32'h0);
                    check("rst bus_we", 32'(bus_we_o), 32'h0);
                    check("rst bus_addr", bus_addr_o, 32'h0);
                    check("rst bus_be", 32'(bus_be_o), 32'h0);
                    check("rst bus_wdata", bus_wdata_o, 32'h0);
                    check("rst read_data", read_data_m_o, 32'h0);
                    check("rst bus_err", 32'(bus_err_o), 32'h0);
                    check("rst stall", 32'(stall_o), 32'h0);
                end
                prev_rst = 1'b0;
                if (misalign_o) begin
                    if (mis_q.size() == 0) fail_evt("misalign");
                    else begin
                        m = mis_q.pop_front();
                        check("misalign read_data", read_data_m_o, m);
                        check("misalign stall", 32'(stall_o), 32'h0);
                    end
                end
                if (bus_req_o && !prev_req) begin
                    if (req_q.size() == 0) fail_evt("bus_req");
                    else begin
                        cur = req_q.pop_front();
                        check("req we", 32'(bus_we_o), 32'(cur.we));
                        check("req addr", bus_addr_o, cur.addr);
                        check("req be", 32'(bus_be_o), 32'(cur.be));
                        if (cur.we) check("req wdata", bus_wdata_o, cur.wdata);
                    end
                end else if (bus_req_o) begin
                    check("req hold addr", bus_addr_o, cur.addr);
                    check("req hold be", 32'(bus_be_o), 32'(cur.be));
                end
                if (stall_o) begin
                    stall_cnt++;
                end else if (stall_cnt > 0) begin
                    if (done_q.size() == 0) fail_evt("completion");
                    else begin
                        d = done_q.pop_front();
                        check("done read_data", read_data_m_o, d.rdata);
                        check("done bus_err", 32'(bus_err_o), 32'(d.err));
                        check("done stall cycles", 32'(stall_cnt), 32'(d.stalls));
                        check("done bus_req", 32'(bus_req_o), 32'h0);
                    end
                    stall_cnt = 0;
                end else if (bus_err_o) begin
                    fail_evt("bus_err");
                end
                prev_req = bus_req_o;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic        rd, wr, uns;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          w;
        rst_i = 1'b1;
        mem_read_m_i = 1'b0; mem_write_m_i = 1'b0; mem_size_m_i = 2'b00;
        mem_unsigned_m_i = 1'b0; addr_m_i = 32'h0; write_data_m_i = 32'h0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        model_rdata = 32'h0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 3, 32'h1234_5678);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0);
        idle_cycle();
        do_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h300, 32'h0BAD_F00D, 1, 32'h5555_5555);
        do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h402, 32'h0, 2, 32'h8001_7FFF);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, -1, 32'h0);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h601, 32'h0, 0, 32'h0000_A500);
        reset_mid_wait(32'h700);
        idle_cycle();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle();
            end else begin
                rd   = 1'($urandom_range(0, 1));
                wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                sz   = 2'($urandom_range(0, 3));
                uns  = 1'($urandom_range(0, 1));
                addr = $urandom;
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                w = $urandom_range(0, 4);
                do_op(rd, wr, sz, uns, addr, $urandom, (w == 4) ? -1 : w, $urandom);
            end
        end

        repeat (3) idle_cycle();
        check("req queue drained", 32'(req_q.size()), 32'h0);
        check("done queue drained", 32'(done_q.size()), 32'h0);
        check("misalign queue drained", 32'(mis_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
